// File: rtl/instr_control_sequencer.sv
// Hardwired control sequencer: fetches (T0-T2) and executes (T3-T6) ALU3, mul/div, nop and halt
// instructions by decoding the datapath IR into per-cycle control strobes.
module instr_control_sequencer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             run,
   input  logic             mem_ready,
   input  logic [31:0]      ir,
   output logic             PCout,
   output logic             Zlowout,
   output logic             Zhighout,
   output logic             MDRout,
   output logic             MARin,
   output logic             Zin,
   output logic             PCin,
   output logic             MDRin,
   output logic             IRin,
   output logic             Yin,
   output logic             IncPC,
   output logic             Read,
   output logic             HIin,
   output logic             LOin,
   output logic [15:0]      Rout,
   output logic [15:0]      Rin,
   output logic [4:0]       opcode,
   output logic             halted,
   output logic             illegal_op,
   output logic [CNT_W-1:0] instr_count
);

   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_T0   = 4'd1;
   localparam logic [3:0] S_T1   = 4'd2;
   localparam logic [3:0] S_T2   = 4'd3;
   localparam logic [3:0] S_T3   = 4'd4;
   localparam logic [3:0] S_T4   = 4'd5;
   localparam logic [3:0] S_T5   = 4'd6;
   localparam logic [3:0] S_T6   = 4'd7;
   localparam logic [3:0] S_HALT = 4'd8;

   logic [3:0] state;
   logic [3:0] state_nxt;
   logic       retire;

   logic [4:0] op;
   logic [3:0] ra;
   logic [3:0] rb;
   logic [3:0] rc;
   logic       is_alu;
   logic       is_md;
   logic       is_nop;
   logic       is_halt;
   logic       ir_unused;

   // IR field and opcode-class decode
   assign op        = ir[31:27];
   assign ra        = ir[26:23];
   assign rb        = ir[22:19];
   assign rc        = ir[18:15];
   assign ir_unused = ^ir[14:0];
   assign is_alu    = (op <= 5'd12);
   assign is_md     = (op == 5'd15) || (op == 5'd16);
   assign is_nop    = (op == 5'd26);
   assign is_halt   = (op == 5'd27);

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and strobe decode; run only matters in IDLE and at the retire cycle
   always_comb begin
      state_nxt  = state;
      retire     = 1'b0;
      PCout      = 1'b0;
      Zlowout    = 1'b0;
      Zhighout   = 1'b0;
      MDRout     = 1'b0;
      MARin      = 1'b0;
      Zin        = 1'b0;
      PCin       = 1'b0;
      MDRin      = 1'b0;
      IRin       = 1'b0;
      Yin        = 1'b0;
      IncPC      = 1'b0;
      Read       = 1'b0;
      HIin       = 1'b0;
      LOin       = 1'b0;
      Rout       = 16'd0;
      Rin        = 16'd0;
      opcode     = 5'd0;
      halted     = 1'b0;
      illegal_op = 1'b0;
      case (state)
         S_IDLE: begin
            if (run) state_nxt = S_T0;
         end
         S_T0: begin
            PCout     = 1'b1;
            MARin     = 1'b1;
            IncPC     = 1'b1;
            Zin       = 1'b1;
            state_nxt = S_T1;
         end
         S_T1: begin
            // Strobes stay up across the memory wait; reloading PC from Z is idempotent
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
            if (mem_ready) state_nxt = S_T2;
         end
         S_T2: begin
            MDRout    = 1'b1;
            IRin      = 1'b1;
            state_nxt = S_T3;
         end
         S_T3: begin
            if (is_alu) begin
               Rout      = 16'd1 << rb;
               Yin       = 1'b1;
               state_nxt = S_T4;
            end else if (is_md) begin
               Rout      = 16'd1 << ra;
               Yin       = 1'b1;
               state_nxt = S_T4;
            end else if (is_halt) begin
               retire    = 1'b1;
               state_nxt = S_HALT;
            end else begin
               illegal_op = !is_nop;
               retire     = is_nop;
               state_nxt  = run ? S_T0 : S_IDLE;
            end
         end
         S_T4: begin
            Rout      = is_md ? (16'd1 << rb) : (16'd1 << rc);
            Zin       = 1'b1;
            opcode    = op;
            state_nxt = S_T5;
         end
         S_T5: begin
            Zlowout = 1'b1;
            if (is_md) begin
               LOin      = 1'b1;
               state_nxt = S_T6;
            end else begin
               Rin       = 16'd1 << ra;
               retire    = 1'b1;
               state_nxt = run ? S_T0 : S_IDLE;
            end
         end
         S_T6: begin
            Zhighout  = 1'b1;
            HIin      = 1'b1;
            retire    = 1'b1;
            state_nxt = run ? S_T0 : S_IDLE;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Retired-instruction counter, wraps naturally at 2^CNT_W
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         instr_count <= '0;
      end else if (retire) begin
         instr_count <= instr_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_instr_control_sequencer.sv
// Scoreboard bench: stimulus pushes per-cycle expected strobes from an instruction-level model;
// a negedge monitor pops and compares against the sequencer outputs every cycle.
module tb_instr_control_sequencer;

   typedef struct packed {
      logic        pc_out, zlo_out, zhi_out, mdr_out, mar_in, z_in, pc_in, mdr_in;
      logic        ir_in, y_in, inc_pc, rd, hi_in, lo_in, halted, illegal;
      logic [15:0] rout;
      logic [15:0] rin;
      logic [4:0]  opc;
      logic [3:0]  cnt;
   } obs_t;

   logic        clock;
   logic        clear;
   logic        run;
   logic        mem_ready;
   logic [31:0] ir;
   logic        PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin;
   logic        IRin, Yin, IncPC, Read, HIin, LOin, halted, illegal_op;
   logic [15:0] Rout;
   logic [15:0] Rin;
   logic [4:0]  opcode;
   logic [3:0]  instr_count;

   obs_t        sb[$];
   logic [3:0]  mcnt;
   int          checks;
   int          errors;
   int          ncyc;

   instr_control_sequencer #(.CNT_W(4)) dut (
      .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
      .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
      .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .IncPC(IncPC), .Read(Read), .HIin(HIin), .LOin(LOin), .Rout(Rout), .Rin(Rin),
      .opcode(opcode), .halted(halted), .illegal_op(illegal_op), .instr_count(instr_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic obs_t sample();
      return {PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin,
              IRin, Yin, IncPC, Read, HIin, LOin, halted, illegal_op,
              Rout, Rin, opcode, instr_count};
   endfunction

   // Monitor: every cycle the DUT presents one output vector
   always @(negedge clock) begin
      obs_t got;
      obs_t want;
      ncyc = ncyc + 1;
      if (sb.size() > 0) begin
         want = sb.pop_front();
         got  = sample();
         checks = checks + 1;
         if (got !== want) begin
            errors = errors + 1;
            $display("FAIL obs cycle %0d got %h expected %h", ncyc, got, want);
         end
      end
   end

   function automatic obs_t blank();
      obs_t b;
      b     = '0;
      b.cnt = mcnt;
      return b;
   endfunction

   function automatic logic rbit();
      return ($urandom & 32'd1) != 32'd0;
   endfunction

   task automatic cyc(input logic [31:0] irv, input logic mr, input logic rn, input obs_t e);
      @(posedge clock);
      #1;
      ir        = irv;
      mem_ready = mr;
      run       = rn;
      sb.push_back(e);
   endtask

   // Asynchronous clear between edges, held two cycles, released with run low
   task automatic do_clear(input logic [31:0] irv);
      obs_t got;
      @(posedge clock);
      #1;
      ir        = irv;
      run       = 1'b0;
      mem_ready = 1'b0;
      #2;
      clear = 1'b0;
      mcnt  = 4'd0;
      #1;
      got    = sample();
      checks = checks + 1;
      if (got !== obs_t'(0)) begin
         errors = errors + 1;
         $display("FAIL reset state at %0t got %h expected all zero", $time, got);
      end
      sb.push_back(blank());
      cyc(irv, 1'b0, 1'b0, blank());
      cyc(irv, 1'b0, 1'b0, blank());
      clear = 1'b1;
      cyc(irv, 1'b0, 1'b0, blank());
      cyc(irv, 1'b0, 1'b0, blank());
      cyc(irv, 1'b0, 1'b1, blank());
   endtask

   // One instruction as a list of micro-steps; retirement advances the model counter
   task automatic run_instr(input logic [31:0] irv, input int stalls, input logic run_end,
                            input logic abort);
      logic [4:0] op;
      obs_t       e;
      op = irv[31:27];
      e = blank(); e.pc_out = 1'b1; e.mar_in = 1'b1; e.inc_pc = 1'b1; e.z_in = 1'b1;
      cyc(irv, rbit(), rbit(), e);
      e = blank(); e.zlo_out = 1'b1; e.pc_in = 1'b1; e.rd = 1'b1; e.mdr_in = 1'b1;
      for (int s = 0; s < stalls; s++) cyc(irv, 1'b0, rbit(), e);
      cyc(irv, 1'b1, rbit(), e);
      e = blank(); e.mdr_out = 1'b1; e.ir_in = 1'b1;
      cyc(irv, rbit(), rbit(), e);
      if (op <= 5'd12) begin
         e = blank(); e.rout = 16'(1) << irv[22:19]; e.y_in = 1'b1;
         cyc(irv, rbit(), rbit(), e);
         if (abort) begin
            do_clear(irv);
            return;
         end
         e = blank(); e.rout = 16'(1) << irv[18:15]; e.z_in = 1'b1; e.opc = op;
         cyc(irv, rbit(), rbit(), e);
         e = blank(); e.zlo_out = 1'b1; e.rin = 16'(1) << irv[26:23];
         cyc(irv, rbit(), run_end, e);
         mcnt = mcnt + 4'd1;
      end else if (op == 5'd15 || op == 5'd16) begin
         e = blank(); e.rout = 16'(1) << irv[26:23]; e.y_in = 1'b1;
         cyc(irv, rbit(), rbit(), e);
         if (abort) begin
            do_clear(irv);
            return;
         end
         e = blank(); e.rout = 16'(1) << irv[22:19]; e.z_in = 1'b1; e.opc = op;
         cyc(irv, rbit(), rbit(), e);
         e = blank(); e.zlo_out = 1'b1; e.lo_in = 1'b1;
         cyc(irv, rbit(), rbit(), e);
         e = blank(); e.zhi_out = 1'b1; e.hi_in = 1'b1;
         cyc(irv, rbit(), run_end, e);
         mcnt = mcnt + 4'd1;
      end else if (op == 5'd26) begin
         cyc(irv, rbit(), run_end, blank());
         mcnt = mcnt + 4'd1;
      end else if (op == 5'd27) begin
         cyc(irv, rbit(), rbit(), blank());
         mcnt = mcnt + 4'd1;
         return;
      end else begin
         e = blank(); e.illegal = 1'b1;
         cyc(irv, rbit(), run_end, e);
      end
      if (!run_end) begin
         int n;
         n = int'($urandom_range(3, 1));
         for (int i = 0; i < n; i++) cyc(irv, rbit(), (i == n - 1), blank());
      end
   endtask

   initial begin
      logic [31:0] irv;
      logic [4:0]  op;
      obs_t        e;
      int          w;
      checks    = 0;
      errors    = 0;
      ncyc      = 0;
      mcnt      = 4'd0;
      clear     = 1'b0;
      run       = 1'b0;
      mem_ready = 1'b0;
      ir        = 32'd0;
      cyc(32'd0, 1'b0, 1'b1, blank());
      cyc(32'd0, 1'b0, 1'b0, blank());
      clear = 1'b1;
      cyc(32'd0, 1'b0, 1'b0, blank());
      cyc(32'd0, 1'b0, 1'b1, blank());

      run_instr(32'h18918000, 0, 1'b1, 1'b0);
      run_instr(32'h7A280000, 0, 1'b1, 1'b0);
      run_instr(32'h18918000, 3, 1'b1, 1'b0);
      run_instr(32'hF8000000, 0, 1'b1, 1'b0);
      run_instr(32'h18918000, 1, 1'b0, 1'b0);

      for (int k = 0; k < 120; k++) begin
         op = 5'($urandom_range(31, 0));
         if (op == 5'd27) op = 5'd26;
         irv = {op, 27'($urandom)};
         run_instr(irv, int'($urandom_range(3, 0)), ($urandom_range(3, 0) != 0), 1'b0);
      end

      for (int k = 0; k < 18; k++) run_instr({5'd26, 27'($urandom)}, 0, 1'b1, 1'b0);

      run_instr(32'h7A280000, 0, 1'b1, 1'b1);
      run_instr(32'h18918000, 0, 1'b1, 1'b0);
      run_instr(32'hD8000000, 2, 1'b1, 1'b0);
      e = blank(); e.halted = 1'b1;
      for (int k = 0; k < 5; k++) cyc(32'hD8000000, rbit(), rbit(), e);
      do_clear(32'hD8000000);

      w = 0;
      while (sb.size() > 0 && w < 4) begin
         @(negedge clock);
         w = w + 1;
      end
      #1;
      checks = checks + 1;
      if (sb.size() != 0) begin
         errors = errors + 1;
         $display("FAIL wait expired with %0d expected cycles unobserved", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
